// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared constants and types for the XCrypto issue queue
package riscv_defines;

    localparam logic [6:0] OPCODE_XCRYPTO = 7'h2b;

    localparam int XCR_DEPTH_DEFAULT = 4;
    localparam int XCR_RD_LSB        = 7;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        kill;
    } xcr_entry_t;

endpackage

// File: rtl/riscv_xcr_scoreboard.sv
// rtl/riscv_xcr_scoreboard.sv - per-register busy vector from live queue entries
module riscv_xcr_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH*5-1:0] entry_rd,
    input  logic [DEPTH-1:0]   entry_valid,
    input  logic [DEPTH-1:0]   entry_kill,
    output logic [31:0]        rd_busy
);

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !entry_kill[i]) begin
                rd_busy[entry_rd[i*5 +: 5]] = 1'b1;
            end
        end
        // x0 is never a real hazard
        rd_busy[0] = 1'b0;
    end

endmodule

// File: rtl/riscv_xcr_issue_queue.sv
// rtl/riscv_xcr_issue_queue.sv - in-order issue/retire queue to the XCrypto coprocessor
module riscv_xcr_issue_queue
    import riscv_defines::*;
#(
    parameter int DEPTH       = XCR_DEPTH_DEFAULT,
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid_i,
    output logic                     id_ready_o,
    input  logic [INSTR_WIDTH-1:0]   id_instr_i,
    input  logic [DATA_WIDTH-1:0]    id_rs1_i,
    input  logic [DATA_WIDTH-1:0]    id_rs2_i,
    output logic                     id_illegal_o,
    output logic                     cop_req_valid_o,
    input  logic                     cop_req_ready_i,
    output logic [INSTR_WIDTH-1:0]   cop_req_instr_o,
    output logic [DATA_WIDTH-1:0]    cop_req_rs1_o,
    output logic [DATA_WIDTH-1:0]    cop_req_rs2_o,
    input  logic                     cop_rsp_valid_i,
    output logic                     cop_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0]    cop_rsp_data_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [4:0]               wb_rd_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic                     flush_i,
    output logic [31:0]              rd_busy_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [DATA_WIDTH-1:0]  rs1_q   [DEPTH];
    logic [DATA_WIDTH-1:0]  rs2_q   [DEPTH];
    logic [DEPTH-1:0]       kill_q;
    logic                   err_q;

    logic [PW-1:0] wr_ptr, iss_ptr, ret_ptr, iss_ptr_nxt, count;
    logic [AW-1:0] wr_idx, iss_idx, ret_idx;
    logic          full, is_xcr, enq, iss_valid, iss_fire;
    logic          head_valid, head_kill, rsp_fire;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign iss_idx = iss_ptr[AW-1:0];
    assign ret_idx = ret_ptr[AW-1:0];

    assign count = wr_ptr - ret_ptr;
    assign full  = (count == PW'(DEPTH));

    assign is_xcr       = (id_instr_i[6:0] == OPCODE_XCRYPTO);
    assign id_ready_o   = !full && !flush_i && !rst;
    assign id_illegal_o = id_valid_i && !is_xcr && !rst;
    assign enq          = id_valid_i && id_ready_o && is_xcr;

    assign iss_valid       = (iss_ptr != wr_ptr);
    assign cop_req_valid_o = iss_valid && !rst;
    assign cop_req_instr_o = cop_req_valid_o ? instr_q[iss_idx] : '0;
    assign cop_req_rs1_o   = cop_req_valid_o ? rs1_q[iss_idx]   : '0;
    assign cop_req_rs2_o   = cop_req_valid_o ? rs2_q[iss_idx]   : '0;
    assign iss_fire        = cop_req_valid_o && cop_req_ready_i;
    assign iss_ptr_nxt     = iss_ptr + PW'(iss_fire);

    // A response with nothing in flight is swallowed so the coprocessor cannot wedge
    assign head_valid      = (ret_ptr != iss_ptr);
    assign head_kill       = kill_q[ret_idx];
    assign cop_rsp_ready_o = !rst && (!head_valid || head_kill || wb_ready_i);
    assign wb_valid_o      = !rst && cop_rsp_valid_i && head_valid && !head_kill;
    assign wb_rd_o         = wb_valid_o ? instr_q[ret_idx][XCR_RD_LSB +: 5] : '0;
    assign wb_data_o       = wb_valid_o ? cop_rsp_data_i : '0;
    assign rsp_fire        = cop_rsp_valid_i && cop_rsp_ready_o && head_valid;

    assign count_o = rst ? '0 : count;
    assign err_o   = err_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            ret_ptr <= '0;
            kill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            iss_ptr <= iss_ptr_nxt;
            if (rsp_fire) begin
                ret_ptr <= ret_ptr + PW'(1);
            end
            if (cop_rsp_valid_i && !head_valid) begin
                err_q <= 1'b1;
            end
            // Flush rewinds the write pointer past anything not yet issued
            if (flush_i) begin
                wr_ptr <= iss_ptr_nxt;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!(rsp_fire && AW'(i) == ret_idx)) begin
                        kill_q[i] <= 1'b1;
                    end
                end
            end else if (enq) begin
                wr_ptr         <= wr_ptr + PW'(1);
                kill_q[wr_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[wr_idx] <= id_instr_i;
            rs1_q[wr_idx]   <= id_rs1_i;
            rs2_q[wr_idx]   <= id_rs2_i;
        end
    end

    logic [DEPTH*5-1:0] entry_rd;
    logic [DEPTH-1:0]   entry_valid;
    logic [PW-1:0]      entry_off [DEPTH];
    logic [31:0]        busy;

    always_comb begin
        entry_rd    = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_off[i]       = PW'(i) - ret_ptr;
            entry_rd[i*5 +: 5] = instr_q[i][XCR_RD_LSB +: 5];
            entry_valid[i]     = ({1'b0, entry_off[i][AW-1:0]} < count);
        end
    end

    riscv_xcr_scoreboard #(
        .DEPTH(DEPTH)
    ) u_scoreboard (
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid),
        .entry_kill  (kill_q),
        .rd_busy     (busy)
    );

    assign rd_busy_o = rst ? '0 : busy;

endmodule

// File: tb/tb_riscv_xcr_issue_queue.sv
// tb/tb_riscv_xcr_issue_queue.sv - directed self-checking bench for riscv_xcr_issue_queue
module tb_riscv_xcr_issue_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid_i = 1'b0;
    logic        id_ready_o;
    logic [31:0] id_instr_i = '0;
    logic [31:0] id_rs1_i = '0;
    logic [31:0] id_rs2_i = '0;
    logic        id_illegal_o;
    logic        cop_req_valid_o;
    logic        cop_req_ready_i = 1'b0;
    logic [31:0] cop_req_instr_o;
    logic [31:0] cop_req_rs1_o;
    logic [31:0] cop_req_rs2_o;
    logic        cop_rsp_valid_i = 1'b0;
    logic        cop_rsp_ready_o;
    logic [31:0] cop_rsp_data_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        flush_i = 1'b0;
    logic [31:0] rd_busy_o;
    logic [2:0]  count_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_xcr_issue_queue #(
        .DEPTH(4), .DATA_WIDTH(32), .INSTR_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_illegal_o(id_illegal_o),
        .cop_req_valid_o(cop_req_valid_o), .cop_req_ready_i(cop_req_ready_i),
        .cop_req_instr_o(cop_req_instr_o), .cop_req_rs1_o(cop_req_rs1_o),
        .cop_req_rs2_o(cop_req_rs2_o), .cop_rsp_valid_i(cop_rsp_valid_i),
        .cop_rsp_ready_o(cop_rsp_ready_o), .cop_rsp_data_i(cop_rsp_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .flush_i(flush_i), .rd_busy_o(rd_busy_o),
        .count_o(count_o), .err_o(err_o)
    );

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [6:0] op);
        return {20'h0, rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; cop_req_ready_i = 0; cop_rsp_valid_i = 0;
        wb_ready_i = 0; flush_i = 0; cop_rsp_data_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic enq(input logic [4:0] rd);
        id_valid_i = 1; id_instr_i = mk(rd, 7'h2b);
        id_rs1_i = {27'h0, rd}; id_rs2_i = 32'h100 + {27'h0, rd};
        step();
        id_valid_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        step();
        n_cmp++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_id_ready: got %b want 0", id_ready_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
        rst = 0;
        #1;
        n_cmp++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_id_ready: got %b want 1", id_ready_o); end
    endtask

    task automatic test_basic();
        do_reset();
        id_valid_i = 1; id_instr_i = mk(5'd5, 7'h2b);
        id_rs1_i = 32'h1234; id_rs2_i = 32'h5678;
        step();
        id_valid_i = 0;
        n_cmp++; if (cop_req_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_req_valid: got %b want 1", cop_req_valid_o); end
        n_cmp++; if (cop_req_instr_o !== 32'h0000_02ab) begin n_bad++; $display("FAIL basic_req_instr: got %h want 000002ab", cop_req_instr_o); end
        n_cmp++; if ({cop_req_rs1_o, cop_req_rs2_o} !== {32'h1234, 32'h5678}) begin n_bad++; $display("FAIL basic_req_ops: got %h/%h want 1234/5678", cop_req_rs1_o, cop_req_rs2_o); end
        n_cmp++; if (rd_busy_o !== 32'h0000_0020) begin n_bad++; $display("FAIL basic_busy: got %h want 00000020", rd_busy_o); end
        cop_req_ready_i = 1;
        step();
        cop_req_ready_i = 0;
        n_cmp++; if (cop_req_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop: got %b want 0", cop_req_valid_o); end
        cop_rsp_valid_i = 1; cop_rsp_data_i = 32'hCAFE; wb_ready_i = 1;
        #1;
        n_cmp++; if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd5, 32'hCAFE}) begin n_bad++; $display("FAIL basic_wb: got %b/%0d/%h want 1/5/cafe", wb_valid_o, wb_rd_o, wb_data_o); end
        step();
        cop_rsp_valid_i = 0; wb_ready_i = 0;
        n_cmp++; if ({rd_busy_o, count_o} !== {32'h0, 3'd0}) begin n_bad++; $display("FAIL basic_drain: got %h/%0d want 0/0", rd_busy_o, count_o); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) enq(5'(i));
        id_valid_i = 1; id_instr_i = mk(5'd9, 7'h2b);
        n_cmp++; if ({count_o, id_ready_o} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL full_state: got %0d/%b want 4/0", count_o, id_ready_o); end
        step();
        n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL full_hold: got %0d want 4", count_o); end
        cop_req_ready_i = 1;
        step();
        cop_req_ready_i = 0;
        cop_rsp_valid_i = 1; cop_rsp_data_i = 32'h11; wb_ready_i = 1;
        #1;
        n_cmp++; if ({wb_valid_o, wb_rd_o, id_ready_o} !== {1'b1, 5'd1, 1'b0}) begin n_bad++; $display("FAIL full_retire: got %b/%0d/%b want 1/1/0", wb_valid_o, wb_rd_o, id_ready_o); end
        step();
        cop_rsp_valid_i = 0; wb_ready_i = 0;
        n_cmp++; if ({count_o, id_ready_o} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL full_freed: got %0d/%b want 3/1", count_o, id_ready_o); end
        step();
        id_valid_i = 0;
        n_cmp++; if ({count_o, rd_busy_o} !== {3'd4, 32'h0000_021C}) begin n_bad++; $display("FAIL full_fifth: got %0d/%h want 4/0000021c", count_o, rd_busy_o); end
    endtask

    task automatic test_illegal();
        do_reset();
        id_valid_i = 1; id_instr_i = mk(5'd3, 7'h33);
        #1;
        n_cmp++; if (id_illegal_o !== 1'b1) begin n_bad++; $display("FAIL illegal_flag: got %b want 1", id_illegal_o); end
        step();
        n_cmp++; if ({count_o, cop_req_valid_o, rd_busy_o} !== {3'd0, 1'b0, 32'h0}) begin n_bad++; $display("FAIL illegal_noaccept: got %0d/%b/%h want 0/0/0", count_o, cop_req_valid_o, rd_busy_o); end
        id_instr_i = mk(5'd3, 7'h2b);
        #1;
        n_cmp++; if (id_illegal_o !== 1'b0) begin n_bad++; $display("FAIL illegal_clear: got %b want 0", id_illegal_o); end
        id_valid_i = 0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 4; i++) enq(5'(i));
        cop_req_ready_i = 1;
        step();
        step();
        cop_req_ready_i = 0;
        flush_i = 1; id_valid_i = 1; id_instr_i = mk(5'd7, 7'h2b);
        #1;
        n_cmp++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", id_ready_o); end
        step();
        flush_i = 0; id_valid_i = 0;
        n_cmp++; if ({count_o, cop_req_valid_o, rd_busy_o} !== {3'd2, 1'b0, 32'h0}) begin n_bad++; $display("FAIL flush_state: got %0d/%b/%h want 2/0/0", count_o, cop_req_valid_o, rd_busy_o); end
        for (int k = 0; k < 2; k++) begin
            cop_rsp_valid_i = 1; cop_rsp_data_i = 32'hD0 + 32'(k); wb_ready_i = 0;
            #1;
            n_cmp++; if ({cop_rsp_ready_o, wb_valid_o} !== 2'b10) begin n_bad++; $display("FAIL flush_drop%0d: got %b%b want 10", k, cop_rsp_ready_o, wb_valid_o); end
            step();
        end
        cop_rsp_valid_i = 0;
        n_cmp++; if ({count_o, err_o} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL flush_drained: got %0d/%b want 0/0", count_o, err_o); end
    endtask

    task automatic test_flush_combo();
        do_reset();
        for (int i = 1; i <= 3; i++) enq(5'(i));
        cop_req_ready_i = 1;
        step();
        flush_i = 1; cop_rsp_valid_i = 1; cop_rsp_data_i = 32'hAAAA; wb_ready_i = 1;
        #1;
        n_cmp++; if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd1, 32'hAAAA}) begin n_bad++; $display("FAIL combo_wb: got %b/%0d/%h want 1/1/aaaa", wb_valid_o, wb_rd_o, wb_data_o); end
        step();
        flush_i = 0; cop_req_ready_i = 0; cop_rsp_valid_i = 0;
        n_cmp++; if ({count_o, cop_req_valid_o, rd_busy_o} !== {3'd1, 1'b0, 32'h0}) begin n_bad++; $display("FAIL combo_state: got %0d/%b/%h want 1/0/0", count_o, cop_req_valid_o, rd_busy_o); end
        cop_rsp_valid_i = 1; cop_rsp_data_i = 32'hBBBB;
        #1;
        n_cmp++; if ({cop_rsp_ready_o, wb_valid_o} !== 2'b10) begin n_bad++; $display("FAIL combo_drop: got %b%b want 10", cop_rsp_ready_o, wb_valid_o); end
        step();
        cop_rsp_valid_i = 0; wb_ready_i = 0;
        n_cmp++; if ({count_o, err_o} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL combo_drained: got %0d/%b want 0/0", count_o, err_o); end
    endtask

    task automatic test_error_and_reset();
        do_reset();
        cop_rsp_valid_i = 1; cop_rsp_data_i = 32'hEE;
        #1;
        n_cmp++; if ({cop_rsp_ready_o, wb_valid_o} !== 2'b10) begin n_bad++; $display("FAIL err_ignore: got %b%b want 10", cop_rsp_ready_o, wb_valid_o); end
        step();
        cop_rsp_valid_i = 0;
        step();
        step();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
        enq(5'd6);
        enq(5'd7);
        id_valid_i = 1; id_instr_i = mk(5'd8, 7'h2b);
        rst = 1;
        #1;
        n_cmp++; if ({id_ready_o, id_illegal_o, cop_req_valid_o, count_o, rd_busy_o, err_o} !== 38'h0) begin n_bad++; $display("FAIL rst_outputs: got %b/%b/%b/%0d/%h/%b want all 0", id_ready_o, id_illegal_o, cop_req_valid_o, count_o, rd_busy_o, err_o); end
        step();
        rst = 0; id_valid_i = 0;
        #1;
        n_cmp++; if ({count_o, err_o, id_ready_o, cop_req_valid_o} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL rst_after: got %0d/%b/%b/%b want 0/0/1/0", count_o, err_o, id_ready_o, cop_req_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_illegal();
        test_flush();
        test_flush_combo();
        test_error_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_xcr_issue_queue.md
# riscv_xcr_issue_queue

Parametrised in-order issue queue between the RI5CY ID stage and an external XCrypto coprocessor. It accepts only OPCODE_XCRYPTO (7'h2b) instructions together with their operands and buffers up to DEPTH of them. Instructions issue to the coprocessor over a valid/ready handshake, and results are written back in order to the register file. It publishes a per-register busy scoreboard for hazard stalls and supports a pipeline flush that squashes queued and in-flight work.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2 to 16
- DATA_WIDTH, 32, operand/result width
- INSTR_WIDTH, 32, instruction word width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset; one clock
- id_valid_i  in  1  ID offers an instruction
- id_ready_o  out  1  queue accepts this cycle
- id_instr_i  in  INSTR_WIDTH  instruction; rd = [11:7], opcode = [6:0]
- id_rs1_i, id_rs2_i  in  DATA_WIDTH  operand values
- id_illegal_o  out  1  offered opcode ≠ OPCODE_XCRYPTO
- cop_req_valid_o  out  1  request to coprocessor
- cop_req_ready_i  in  1  coprocessor accepts
- cop_req_instr_o  out  INSTR_WIDTH  issued instruction
- cop_req_rs1_o, cop_req_rs2_o  out  DATA_WIDTH  issued operands
- cop_rsp_valid_i  in  1  result available; results arrive in issue order
- cop_rsp_ready_o  out  1  result consumed
- cop_rsp_data_i  in  DATA_WIDTH  result
- wb_valid_o  out  1  write-back request
- wb_ready_i  in  1  register file port granted
- wb_rd_o  out  5  destination register
- wb_data_o  out  DATA_WIDTH  write-back data
- flush_i  in  1  squash all non-retiring entries
- rd_busy_o  out  32  bit r = a live entry targets x_r; bit 0 is always 0
- count_o  out  $clog2(DEPTH)+1  occupied entries
- err_o  out  1  sticky protocol error

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {instr, rs1, rs2, kill}. There are three pointers, wr_ptr, iss_ptr and ret_ptr, each $clog2(DEPTH)+1 bits with a wrap bit.
- count = wr_ptr − ret_ptr. The buffer is full when count == DEPTH and empty when count == 0.
- Enqueue:
  - id_ready_o = !full && !flush_i && !rst.
  - A handshake with opcode OPCODE_XCRYPTO writes the entry at wr_ptr with kill=0, then increments wr_ptr.
  - Any other opcode drives id_illegal_o=1 combinationally and is never accepted. ID raises the illegal-instruction exception.
- Issue:
  - cop_req_valid_o = (iss_ptr ≠ wr_ptr). The payload is the entry at iss_ptr.
  - A handshake increments iss_ptr.
  - Valid and payload stay stable until ready. The only exception is after a flush, when the request is withdrawn.
- Retire:
  - The head entry is at ret_ptr and is valid only if ret_ptr ≠ iss_ptr.
  - cop_rsp_ready_o = kill[ret] || wb_ready_i.
  - wb_valid_o = cop_rsp_valid_i && !kill[ret]. wb_rd_o = instr[ret][11:7] and wb_data_o = cop_rsp_data_i.
  - A response handshake increments ret_ptr. A killed entry's result is dropped silently.
- Flush:
  - Every entry except one retiring this cycle gets kill=1.
  - wr_ptr loads the iss_ptr value as updated this cycle, so an issue handshake in the same cycle completes and that entry becomes in-flight and killed.
  - Issued entries stay allocated until their response drains.
- Scoreboard: rd_busy_o[r] = OR over allocated, non-killed entries of (rd == r), for r ≠ 0.
- Error: cop_rsp_valid_i while ret_ptr == iss_ptr sets err_o, which clears only on rst. The response is ignored (cop_rsp_ready_o=1, wb_valid_o=0).

## Timing
- Reset values: all pointers 0, all kill bits 0, err_o=0. Every output is 0 during the reset cycle, including id_ready_o. id_ready_o rises in the first cycle after reset.
- Enqueue at edge N makes cop_req_valid_o high in cycle N+1. Minimum ID-to-issue latency is 1 cycle.
- Response to write-back is combinational (0 cycles).
- rd_busy_o and count_o reflect the registered state after edge N, so a same-cycle enqueue becomes visible one cycle later.
- Simultaneous events:
  - Enqueue and retire when full: id_ready_o stays 0. Full is registered; no bypass.
  - Flush and enqueue: flush wins, nothing is accepted.
  - Flush and retire: the retiring entry writes back if wb_ready_i.
- Rst mid-operation drops everything. The coprocessor is reset by the same rst.

## Structure
- Add to riscv_defines:
  - XCR_DEPTH_DEFAULT = 4
  - XCR_RD_LSB = 7
  - a packed struct typedef xcr_entry_t {instr, rs1, rs2, kill}
  - OPCODE_XCRYPTO is reused as is.
- One sub-module, riscv_xcr_scoreboard: DEPTH-entry rd/valid/kill vectors in, rd_busy_o out, purely combinational.
- Pointer/FIFO logic lives in the top module.

## Test plan
- Enqueue rd=x5 with rs1=32'h1234, rs2=32'h5678 → cycle+1 cop_req_valid_o=1 with the same payload, rd_busy_o[5]=1. Response 32'hCAFE → wb_rd_o=5, wb_data_o=32'hCAFE, rd_busy_o[5]=0 the next cycle.
- DEPTH=4, cop_req_ready_i=0, offer 5 instructions → 4 accepted, count_o=4, id_ready_o=0. The 5th is accepted only after the first retires.
- Offer opcode 7'h33 → id_illegal_o=1, id_ready_o handshake not taken, count_o unchanged.
- 2 issued, 2 queued, then flush_i → count_o=2, cop_req_valid_o=0. The next 2 responses give cop_rsp_ready_o=1, wb_valid_o=0, rd_busy_o=0.
- Flush in the same cycle as an issue handshake and a retiring response with wb_ready_i=1 → retiring result written back, issued entry killed, its later response dropped.
- cop_rsp_valid_i=1 with nothing issued → err_o=1 and stays 1 until rst. Assert rst mid-traffic → count_o=0, all outputs 0 during reset.
